// File: rtl/sprite_stream_loader.sv
// Packet loader for the sprite display stage: SYNC, 3*NPIX payload bytes, checksum.
// The payload is buffered and released as a paced strobe stream only after the checksum passes.
module sprite_stream_loader #(
    parameter int          NPIX      = 100,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          GAP       = 2,
    parameter int          TIMEOUT   = 50000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iRX_DATA,
    input  logic        iRX_VALID,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR
);

    localparam int NBYTES = 3 * NPIX;
    localparam int IW     = $clog2(NBYTES + 1);
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(NBYTES - 1);
    localparam logic [IW-1:0] END_IDX    = IW'(NBYTES);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_CSUM    = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_q,  state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    sum_q,    sum_d;
    logic [TW-1:0] tmo_q,    tmo_d;
    logic [GW-1:0] gap_q,    gap_d;
    logic          pend_q,   pend_d;
    logic [11:0]   data_q,   data_d;
    logic          dval_q,   dval_d;
    logic          err_q,    err_d;

    logic          wr_en;
    logic          rd_en;
    logic [7:0]    csum_chk;
    logic [7:0]    rdata_q;
    logic [7:0]    mem [NBYTES];

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        pend_d   = 1'b0;
        data_d   = data_q;
        dval_d   = 1'b0;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        csum_chk = sum_q + iRX_DATA;

        case (state_q)
            S_IDLE: begin
                if (iRX_VALID && (iRX_DATA == SYNC_BYTE)) begin
                    state_d  = S_PAYLOAD;
                    wr_idx_d = '0;
                    sum_d    = '0;
                    tmo_d    = '0;
                end
            end
            S_PAYLOAD: begin
                if (iRX_VALID) begin
                    wr_en    = 1'b1;
                    sum_d    = csum_chk;
                    wr_idx_d = wr_idx_q + 1'b1;
                    tmo_d    = '0;
                    if (wr_idx_q == LAST_IDX) state_d = S_CSUM;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CSUM: begin
                if (iRX_VALID) begin
                    tmo_d = '0;
                    if (csum_chk == 8'h00) begin
                        state_d  = S_EMIT;
                        rd_idx_d = '0;
                        gap_d    = '0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_EMIT: begin
                // A read issued last cycle becomes this cycle's strobe; the final one ends the stream.
                if (pend_q) begin
                    dval_d = 1'b1;
                    data_d = {4'h0, rdata_q};
                    if (rd_idx_q == END_IDX) state_d = S_DONE;
                end
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (rd_idx_q != END_IDX) begin
                    rd_en    = 1'b1;
                    pend_d   = 1'b1;
                    rd_idx_d = rd_idx_q + 1'b1;
                    gap_d    = GAP_RELOAD;
                end
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= S_IDLE;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            sum_q    <= '0;
            tmo_q    <= '0;
            gap_q    <= '0;
            pend_q   <= 1'b0;
            data_q   <= '0;
            dval_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            sum_q    <= sum_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            data_q   <= data_d;
            dval_q   <= dval_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the payload buffer has no reset so it can map onto a plain synchronous RAM.
    always_ff @(posedge iCLK) begin
        if (wr_en) mem[wr_idx_q] <= iRX_DATA;
        if (rd_en) rdata_q <= mem[rd_idx_q];
    end

    assign oDATA = data_q;
    assign oDVAL = dval_q;
    assign oERR  = err_q;
    assign oBUSY = (state_q == S_PAYLOAD) || (state_q == S_CSUM) || (state_q == S_EMIT);
    assign oDONE = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_stream_loader.sv
// Directed bench for sprite_stream_loader: a scoreboard queue holds the bytes each accepted
// packet must release, and a negedge monitor pops and checks every strobe and its pacing.
module tb_sprite_stream_loader;

    localparam int NPIX = 100;
    localparam int NB   = 3 * NPIX;
    localparam int GAP  = 2;
    localparam int TMO  = 1000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [7:0]  iRX_DATA = 8'h00;
    logic        iRX_VALID = 1'b0;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic        oBUSY;
    logic        oDONE;
    logic        oERR;

    sprite_stream_loader #(
        .NPIX(NPIX), .SYNC_BYTE(8'hA5), .GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iRX_DATA(iRX_DATA), .iRX_VALID(iRX_VALID),
        .oDATA(oDATA), .oDVAL(oDVAL), .oBUSY(oBUSY), .oDONE(oDONE), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         err_pulses = 0;
    int         last_cyc = 0;
    int         csum_cyc = 0;
    bit         first_pending = 1'b0;
    logic [7:0] exp_q [$];
    logic [7:0] pay [NB];

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge iCLK) begin
        if (oERR) err_pulses++;
        if (oDVAL) begin
            logic [7:0] e;
            strobes++;
            check("strobe_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_data", oDATA, {4'h0, e});
            end
            if (first_pending) begin
                check("first_latency", cyc - csum_cyc, 2);
                first_pending = 1'b0;
            end else begin
                check("strobe_period", cyc - last_cyc, GAP + 1);
            end
            last_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, output int acc);
        iRX_VALID = 1'b1;
        iRX_DATA  = b;
        @(negedge iCLK);
        acc = cyc;
        iRX_VALID = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic send_packet(input bit good, input logic [7:0] csum_delta);
        logic [7:0] sum;
        int         acc;
        sum = 8'h00;
        for (int k = 0; k < NB; k++) sum = sum + pay[k];
        if (good) for (int k = 0; k < NB; k++) exp_q.push_back(pay[k]);
        send_byte(8'hA5, acc);
        for (int k = 0; k < NB; k++) send_byte(pay[k], acc);
        send_byte(8'h00 - sum + csum_delta, acc);
        if (good) begin
            csum_cyc      = acc;
            first_pending = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!oDONE && n < 4 * NB) begin
            @(negedge iCLK);
            n++;
        end
        check({tag, "_done_in_time"}, oDONE, 1);
        repeat (4) @(negedge iCLK);
        check({tag, "_strobe_count"}, strobes, NB);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_low"}, oBUSY, 0);
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        exp_q.delete();
        first_pending = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        strobes    = 0;
        err_pulses = 0;
    endtask

    initial begin
        int acc;
        int seen;
        int n;
        for (int k = 0; k < NB; k++) pay[k] = 8'(k);

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_data", oDATA, 0);
        check("rst_dval", oDVAL, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_done", oDONE, 0);
        check("rst_err", oERR, 0);
        iRST = 1'b1;
        @(negedge iCLK);

        // Junk in IDLE is ignored, then a good packet
        send_byte(8'h00, acc);
        send_byte(8'h5A, acc);
        check("idle_ignores_junk", oBUSY, 0);
        send_packet(1'b1, 8'h00);
        check("busy_in_emit", oBUSY, 1);
        wait_done("good1");

        // A further packet after DONE releases nothing
        send_packet(1'b0, 8'h00);
        repeat (10) @(negedge iCLK);
        check("after_done_no_strobe", strobes, NB);
        check("after_done_sticky", oDONE, 1);
        check("after_done_no_err", err_pulses, 0);

        // Bad checksum, then a good packet
        do_reset();
        send_packet(1'b0, 8'h01);
        repeat (10) @(negedge iCLK);
        check("badcsum_err_once", err_pulses, 1);
        check("badcsum_no_strobe", strobes, 0);
        check("badcsum_idle", oBUSY, 0);
        send_packet(1'b1, 8'h00);
        wait_done("good2");
        check("good2_no_err", err_pulses, 1);

        // SYNC value inside the payload is data
        do_reset();
        pay[5] = 8'hA5;
        send_packet(1'b1, 8'h00);
        wait_done("sync_in_payload");
        pay[5] = 8'h05;

        // Timeout after 10 payload bytes
        do_reset();
        send_byte(8'hA5, acc);
        for (int k = 0; k < 10; k++) send_byte(pay[k], acc);
        check("timeout_busy_before", oBUSY, 1);
        seen = -1;
        n = 0;
        while (seen < 0 && n < TMO + 20) begin
            if (oERR) seen = cyc;
            else begin
                @(negedge iCLK);
                n++;
            end
        end
        check("timeout_latency", seen - acc, TMO);
        repeat (3) @(negedge iCLK);
        check("timeout_err_once", err_pulses, 1);
        check("timeout_busy_after", oBUSY, 0);
        check("timeout_no_strobe", strobes, 0);

        // Reset at strobe 150, then a fresh packet
        do_reset();
        send_packet(1'b1, 8'h00);
        n = 0;
        while (strobes < NB / 2 && n < 4 * NB) begin
            @(posedge iCLK);
            n++;
        end
        check("reached_strobe_150", strobes, NB / 2);
        #1;
        iRST = 1'b0;
        #1;
        check("midrst_data", oDATA, 0);
        check("midrst_dval", oDVAL, 0);
        check("midrst_busy", oBUSY, 0);
        check("midrst_done", oDONE, 0);
        check("midrst_err", oERR, 0);
        exp_q.delete();
        first_pending = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        strobes = 0;
        err_pulses = 0;
        send_packet(1'b1, 8'h00);
        wait_done("after_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
